alu_issue_decoder: RTL and testbench
====================================

# alu_issue_decoder

Single-stage registered decode slot sitting immediately upstream of the ALU in the RV32I datapath. It accepts one 32-bit instruction plus its PC per valid/ready handshake and decodes it into the ALU operation code and operand selects that the ALU consumes. It also produces the immediate, register addresses, writeback enable and an illegal-instruction flag. It holds the decoded result stable under downstream back-pressure and drops it on flush.

## Interface
- No parameters; widths fixed at RV32I (XLEN 32, 5-bit register indices, 4-bit ALU op).
- i_clk  input  1  clock; all state updates on rising edge.
- i_reset  input  1  asynchronous, active-low reset.
- i_valid  input  1  upstream has an instruction on i_instr/i_pc.
- o_ready  output  1  slot can accept this cycle; equals ~o_valid | i_ready (combinational).
- i_instr  input  32  instruction word.
- i_pc  input  32  PC of i_instr.
- i_flush  input  1  discard slot contents and any same-cycle capture.
- o_valid  output  1  decoded instruction present.
- i_ready  input  1  downstream consumes slot when o_valid & i_ready.
- o_aluOp  output  4  0000 ADD, 0001 SUB, 0010 SLT, 0011 SLTU, 0100 XOR, 0101 OR, 0110 AND, 0111 SLL, 1000 SRL, 1001 SRA, 1010 pass-B (LUI).
- o_opaSel  output  1  0 = rs1, 1 = PC.
- o_opbSel  output  1  0 = rs2, 1 = immediate.
- o_imm  output  32  sign-extended immediate for the format.
- o_rs1, o_rs2, o_rd  output  5 each  instr[19:15], [24:20], [11:7].
- o_wbEn  output  1  instruction writes rd (forced 0 when rd = 0).
- o_pc  output  32  registered i_pc.
- o_illegal  output  1  opcode/funct combination not decoded.

## Operation
- Capture = i_valid & o_ready & ~i_flush. On capture, all outputs load the decode of i_instr/i_pc; o_valid <= 1.
- Consume without capture: o_valid <= 0; data registers hold last value.
- No capture and no consume: all registers hold (stall).
- i_flush: o_valid <= 0 next edge regardless of i_valid/i_ready; data registers may hold.
- Decode by opcode (instr[6:0]):
  - 0110011 OP: opb=rs2; funct3/funct7 map: 000/0000000 ADD, 000/0100000 SUB, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101/0000000 SRL, 101/0100000 SRA, 110 OR, 111 AND. Any other funct7 is illegal.
  - 0010011 OP-IMM: opb=imm (I-type), same funct3 map without SUB. Shifts: imm[11:5] must be 0000000 (SLLI/SRLI) or 0100000 (SRAI only), else illegal. o_imm is the raw sign-extended I-imm; the ALU uses bits [4:0].
  - 0110111 LUI: op 1010, opb=imm (U-type, low 12 bits zero).
  - 0010111 AUIPC: ADD, opa=PC, opb=U-imm.
  - 0000011 LOAD: ADD, rs1+I-imm. 0100011 STORE: ADD, rs1+S-imm, wbEn=0.
  - 1100011 BRANCH: ADD, opa=PC, opb=B-imm (target), wbEn=0.
  - 1101111 JAL: ADD, PC+J-imm. 1100111 JALR (funct3 000): ADD, rs1+I-imm.
- Illegal: o_illegal=1, o_aluOp=0000, o_wbEn=0, o_valid still asserts (the downstream stage raises the trap).
- All unused selects default to 0.

## Timing
- Latency 1 cycle: decode of an instruction captured at edge N is visible after edge N.
- Full throughput: back-to-back captures when i_ready held 1.
- Simultaneous consume and capture in the same cycle: the new instruction replaces the old one and o_valid stays 1.
- While stalled (o_valid & ~i_ready), o_ready=0 and all outputs are bit-stable.
- Reset (asynchronous, any cycle including mid-stall): o_valid=0, o_illegal=0, o_wbEn=0, o_aluOp=0000, o_opaSel=0, o_opbSel=0, o_imm/o_pc=0, o_rs1/o_rs2/o_rd=0. The first capture is possible on the first edge after deassertion.

## Test plan
- Reset: assert i_reset=0 mid-stall with o_valid=1 -> all outputs 0 immediately. After release, o_ready=1.
- OP decode: sub x3,x1,x2 (0x402081B3) -> aluOp 0001, opb=0, rd=3, wbEn=1. sra x3,x1,x2 (0x4020D1B3) -> 1001.
- Immediates: srai x5,x6,7 (0x40735293) -> aluOp 1001, imm 0x00000407. lui x1,0xABCDE (0xABCDE0B7) -> aluOp 1010, imm 0xABCDE000. addi x1,x0,-1 (0xFFF00093) -> imm 0xFFFFFFFF.
- Illegal cases: 0x0000007F -> illegal=1, wbEn=0, o_valid=1. slli with imm[11:5]=0100000 (0x40101093) -> illegal=1.
- Back-pressure: hold i_ready=0 for 3 cycles with i_valid=1 -> o_ready=0 and outputs unchanged. Raise i_ready -> next instruction appears one cycle later with no loss or duplication.
- Flush: i_flush=1 with i_valid=1 and o_valid=1 -> o_valid=0 next cycle and the presented instruction is not captured.

Source files
------------

// File: rtl/alu_issue_decoder.sv
// Single registered decode slot ahead of the ALU: turns one RV32I instruction into
// ALU op, operand selects, immediate, register fields and writeback enable.
module alu_issue_decoder (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_valid,
   output logic        o_ready,
   input  logic [31:0] i_instr,
   input  logic [31:0] i_pc,
   input  logic        i_flush,
   output logic        o_valid,
   input  logic        i_ready,
   output logic [3:0]  o_aluOp,
   output logic        o_opaSel,
   output logic        o_opbSel,
   output logic [31:0] o_imm,
   output logic [4:0]  o_rs1,
   output logic [4:0]  o_rs2,
   output logic [4:0]  o_rd,
   output logic        o_wbEn,
   output logic [31:0] o_pc,
   output logic        o_illegal
);

   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b0001;
   localparam logic [3:0] ALU_SLT  = 4'b0010;
   localparam logic [3:0] ALU_SLTU = 4'b0011;
   localparam logic [3:0] ALU_XOR  = 4'b0100;
   localparam logic [3:0] ALU_OR   = 4'b0101;
   localparam logic [3:0] ALU_AND  = 4'b0110;
   localparam logic [3:0] ALU_SLL  = 4'b0111;
   localparam logic [3:0] ALU_SRL  = 4'b1000;
   localparam logic [3:0] ALU_SRA  = 4'b1001;
   localparam logic [3:0] ALU_PASSB = 4'b1010;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;

   localparam logic [6:0] F7_ZERO = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   // funct3 -> ALU op for the shared OP / OP-IMM table (funct7 = 0 variants)
   function automatic logic [3:0] base_op(input logic [2:0] f3);
      case (f3)
         3'b000:  base_op = ALU_ADD;
         3'b001:  base_op = ALU_SLL;
         3'b010:  base_op = ALU_SLT;
         3'b011:  base_op = ALU_SLTU;
         3'b100:  base_op = ALU_XOR;
         3'b101:  base_op = ALU_SRL;
         3'b110:  base_op = ALU_OR;
         default: base_op = ALU_AND;
      endcase
   endfunction

   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
   logic [3:0]  dec_alu;
   logic        dec_opa, dec_opb, dec_wb, dec_ill;
   logic [31:0] dec_imm;
   logic        capture;

   assign opcode = i_instr[6:0];
   assign funct3 = i_instr[14:12];
   assign funct7 = i_instr[31:25];

   assign imm_i = {{20{i_instr[31]}}, i_instr[31:20]};
   assign imm_s = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
   assign imm_b = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
   assign imm_u = {i_instr[31:12], 12'b0};
   assign imm_j = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};

   always_comb begin
      dec_alu = ALU_ADD;
      dec_opa = 1'b0;
      dec_opb = 1'b0;
      dec_imm = '0;
      dec_wb  = 1'b0;
      dec_ill = 1'b0;
      case (opcode)
         OPC_OP: begin
            dec_wb = 1'b1;
            if (funct7 == F7_ZERO)                          dec_alu = base_op(funct3);
            else if (funct7 == F7_ALT && funct3 == 3'b000) dec_alu = ALU_SUB;
            else if (funct7 == F7_ALT && funct3 == 3'b101) dec_alu = ALU_SRA;
            else                                            dec_ill = 1'b1;
         end
         OPC_OPIMM: begin
            dec_wb  = 1'b1;
            dec_opb = 1'b1;
            dec_imm = imm_i;
            dec_alu = base_op(funct3);
            // shift amount lives in imm[4:0]; imm[11:5] selects logical vs arithmetic
            if (funct3 == 3'b001 && funct7 != F7_ZERO) dec_ill = 1'b1;
            if (funct3 == 3'b101) begin
               if (funct7 == F7_ALT)       dec_alu = ALU_SRA;
               else if (funct7 != F7_ZERO) dec_ill = 1'b1;
            end
         end
         OPC_LUI: begin
            dec_alu = ALU_PASSB;
            dec_opb = 1'b1;
            dec_imm = imm_u;
            dec_wb  = 1'b1;
         end
         OPC_AUIPC: begin
            dec_opa = 1'b1;
            dec_opb = 1'b1;
            dec_imm = imm_u;
            dec_wb  = 1'b1;
         end
         OPC_LOAD: begin
            dec_opb = 1'b1;
            dec_imm = imm_i;
            dec_wb  = 1'b1;
         end
         OPC_STORE: begin
            dec_opb = 1'b1;
            dec_imm = imm_s;
         end
         OPC_BRANCH: begin
            dec_opa = 1'b1;
            dec_opb = 1'b1;
            dec_imm = imm_b;
         end
         OPC_JAL: begin
            dec_opa = 1'b1;
            dec_opb = 1'b1;
            dec_imm = imm_j;
            dec_wb  = 1'b1;
         end
         OPC_JALR: begin
            dec_opb = 1'b1;
            dec_imm = imm_i;
            dec_wb  = 1'b1;
            if (funct3 != 3'b000) dec_ill = 1'b1;
         end
         default: dec_ill = 1'b1;
      endcase
      // illegal instructions travel as a harmless ADD; the trap is raised downstream
      if (dec_ill) begin
         dec_alu = ALU_ADD;
         dec_opa = 1'b0;
         dec_opb = 1'b0;
         dec_imm = '0;
         dec_wb  = 1'b0;
      end
      if (i_instr[11:7] == 5'd0) dec_wb = 1'b0;
   end

   assign o_ready = ~o_valid | i_ready;
   assign capture = i_valid & o_ready & ~i_flush;

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         o_valid   <= 1'b0;
         o_aluOp   <= ALU_ADD;
         o_opaSel  <= 1'b0;
         o_opbSel  <= 1'b0;
         o_imm     <= '0;
         o_rs1     <= '0;
         o_rs2     <= '0;
         o_rd      <= '0;
         o_wbEn    <= 1'b0;
         o_pc      <= '0;
         o_illegal <= 1'b0;
      end else begin
         if (i_flush)      o_valid <= 1'b0;
         else if (capture) o_valid <= 1'b1;
         else if (i_ready) o_valid <= 1'b0;
         if (capture) begin
            o_aluOp   <= dec_alu;
            o_opaSel  <= dec_opa;
            o_opbSel  <= dec_opb;
            o_imm     <= dec_imm;
            o_rs1     <= i_instr[19:15];
            o_rs2     <= i_instr[24:20];
            o_rd      <= i_instr[11:7];
            o_wbEn    <= dec_wb;
            o_pc      <= i_pc;
            o_illegal <= dec_ill;
         end
      end
   end

endmodule

// File: tb/tb_alu_issue_decoder.sv
// Scoreboard bench for alu_issue_decoder: random handshake/flush traffic against a
// spec-level decode model, plus a mid-stall asynchronous reset check.
module tb_alu_issue_decoder;

   logic        i_clk = 1'b0;
   logic        i_reset = 1'b0;
   logic        i_valid = 1'b0;
   logic        o_ready;
   logic [31:0] i_instr = '0;
   logic [31:0] i_pc = '0;
   logic        i_flush = 1'b0;
   logic        o_valid;
   logic        i_ready = 1'b0;
   logic [3:0]  o_aluOp;
   logic        o_opaSel, o_opbSel;
   logic [31:0] o_imm;
   logic [4:0]  o_rs1, o_rs2, o_rd;
   logic        o_wbEn;
   logic [31:0] o_pc;
   logic        o_illegal;

   alu_issue_decoder dut (
      .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready),
      .i_instr(i_instr), .i_pc(i_pc), .i_flush(i_flush), .o_valid(o_valid),
      .i_ready(i_ready), .o_aluOp(o_aluOp), .o_opaSel(o_opaSel), .o_opbSel(o_opbSel),
      .o_imm(o_imm), .o_rs1(o_rs1), .o_rs2(o_rs2), .o_rd(o_rd), .o_wbEn(o_wbEn),
      .o_pc(o_pc), .o_illegal(o_illegal)
   );

   always #5 i_clk = ~i_clk;

   typedef struct packed {
      logic [3:0]  alu;
      logic        opa;
      logic        opb;
      logic [31:0] imm;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic        wb;
      logic [31:0] pc;
      logic        ill;
   } exp_t;

   exp_t q[$];
   int   vectors = 0;
   int   miscompares = 0;
   bit   mon_en = 1'b0;
   bit   mv = 1'b0;

   // ALU op numbering: ADD0 SUB1 SLT2 SLTU3 XOR4 OR5 AND6 SLL7 SRL8 SRA9 PASSB10.
   // SUB and SRA are the funct7=0100000 siblings of ADD and SRL, i.e. op+1.
   function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc);
      int    base[8] = '{0, 7, 2, 3, 4, 8, 5, 6};
      exp_t  e;
      int    op = 0;
      bit    legal = 1, writes = 0;
      logic [31:0] iimm, simm, bimm, uimm, jimm;
      logic [6:0]  opc = ins[6:0];
      logic [2:0]  f3 = ins[14:12];
      logic [6:0]  f7 = ins[31:25];
      iimm = 32'($signed(ins[31:20]));
      simm = 32'($signed({ins[31:25], ins[11:7]}));
      bimm = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
      uimm = ins & 32'hFFFF_F000;
      jimm = 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
      e = '0;
      e.rs1 = ins[19:15];
      e.rs2 = ins[24:20];
      e.rd  = ins[11:7];
      e.pc  = pc;
      case (opc)
         7'h33: begin
            writes = 1;
            if (f7 == 0) op = base[f3];
            else if (f7 == 7'h20 && (f3 == 0 || f3 == 5)) op = base[f3] + 1;
            else legal = 0;
         end
         7'h13: begin
            writes = 1; e.opb = 1; e.imm = iimm; op = base[f3];
            if (f3 == 1 && f7 != 0) legal = 0;
            if (f3 == 5 && f7 == 7'h20) op = 9;
            else if (f3 == 5 && f7 != 0) legal = 0;
         end
         7'h37: begin writes = 1; op = 10; e.opb = 1; e.imm = uimm; end
         7'h17: begin writes = 1; e.opa = 1; e.opb = 1; e.imm = uimm; end
         7'h03: begin writes = 1; e.opb = 1; e.imm = iimm; end
         7'h23: begin e.opb = 1; e.imm = simm; end
         7'h63: begin e.opa = 1; e.opb = 1; e.imm = bimm; end
         7'h6F: begin writes = 1; e.opa = 1; e.opb = 1; e.imm = jimm; end
         7'h67: begin writes = 1; e.opb = 1; e.imm = iimm; legal = (f3 == 0); end
         default: legal = 0;
      endcase
      if (legal) begin
         e.alu = 4'(op);
         e.wb  = writes && (e.rd != 0);
      end else begin
         e.alu = 0; e.opa = 0; e.opb = 0; e.imm = 0; e.wb = 0; e.ill = 1;
      end
      return e;
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // monitor: checks the presented slot against the head of the scoreboard every cycle
   initial begin
      exp_t got;
      forever begin
         @(negedge i_clk);
         #2;
         if (mon_en) begin
            chk("o_valid", 32'(o_valid), 32'(q.size() != 0));
            chk("o_ready", 32'(o_ready), 32'((q.size() == 0) || i_ready));
            if (q.size() != 0) begin
               got = '{o_aluOp, o_opaSel, o_opbSel, o_imm, o_rs1, o_rs2, o_rd, o_wbEn, o_pc, o_illegal};
               vectors++;
               if (got !== q[0]) begin
                  miscompares++;
                  $display("FAIL decode pc=%h: got alu=%h opa=%b opb=%b imm=%h rs1=%0d rs2=%0d rd=%0d wb=%b ill=%b expected alu=%h opa=%b opb=%b imm=%h rs1=%0d rs2=%0d rd=%0d wb=%b ill=%b",
                           q[0].pc, got.alu, got.opa, got.opb, got.imm, got.rs1, got.rs2, got.rd, got.wb, got.ill,
                           q[0].alu, q[0].opa, q[0].opb, q[0].imm, q[0].rs1, q[0].rs2, q[0].rd, q[0].wb, q[0].ill);
               end
               if (i_ready || i_flush) void'(q.pop_front());
            end
         end
      end
   end

   task automatic step(input bit v, input logic [31:0] ins, input logic [31:0] pc,
                       input bit rdy, input bit fl);
      bit   cap;
      exp_t e;
      @(negedge i_clk);
      i_valid = v; i_instr = ins; i_pc = pc; i_ready = rdy; i_flush = fl;
      cap = v && (!mv || rdy) && !fl;
      e = model(ins, pc);
      @(posedge i_clk);
      if (cap) q.push_back(e);
      mv = fl ? 1'b0 : cap ? 1'b1 : rdy ? 1'b0 : mv;
   endtask

   function automatic logic [31:0] rand_instr();
      int opcs[10] = '{'h33, 'h13, 'h37, 'h17, 'h03, 'h23, 'h63, 'h6F, 'h67, 0};
      logic [31:0] ins = $urandom;
      int k = $urandom_range(0, 9);
      int r = $urandom_range(0, 3);
      if (k < 9) ins[6:0] = 7'(opcs[k]);
      if (r == 0) ins[31:25] = 7'h00;
      else if (r == 1) ins[31:25] = 7'h20;
      if ($urandom_range(0, 3) == 0) ins[14:12] = 3'b000;
      return ins;
   endfunction

   logic [31:0] directed[10] = '{32'h402081B3, 32'h4020D1B3, 32'h40735293, 32'hABCDE0B7,
                                 32'hFFF00093, 32'h0000007F, 32'h40101093, 32'h00000013,
                                 32'hFE5FF06F, 32'h00C50067};

   initial begin
      logic [31:0] pc = 32'h0000_1000;
      #12 i_reset = 1'b1;
      mon_en = 1'b1;
      // directed instructions, first one held 3 cycles under back-pressure
      step(1, directed[0], pc, 1, 0);
      for (int k = 0; k < 3; k++) step(1, directed[1], pc + 4, 0, 0);
      pc += 4;
      for (int k = 1; k < 10; k++) begin
         step(1, directed[k], pc, 1, 0);
         pc += 4;
      end
      // flush while holding a stalled instruction and presenting a new one
      step(1, 32'h002081B3, pc, 0, 0);
      step(1, 32'h00000093, pc + 4, 0, 1);
      step(0, 32'h0, pc, 1, 0);
      // random traffic
      for (int k = 0; k < 600; k++) begin
         pc += 4;
         step($urandom_range(0, 3) != 0, rand_instr(), pc,
              $urandom_range(0, 9) < 7, $urandom_range(0, 11) == 0);
      end
      for (int k = 0; k < 3; k++) step(0, 32'h0, pc, 1, 0);
      chk("scoreboard_drained", 32'(q.size()), 32'd0);

      // asynchronous reset in the middle of a stall
      @(negedge i_clk);
      mon_en = 1'b0;
      q.delete();
      i_valid = 1; i_instr = 32'h402081B3; i_pc = 32'hCAFE_0000; i_ready = 0; i_flush = 0;
      @(negedge i_clk);
      i_valid = 0;
      #1 chk("stall_valid", 32'(o_valid), 32'd1);
      chk("stall_ready", 32'(o_ready), 32'd0);
      chk("stall_pc", o_pc, 32'hCAFE_0000);
      #1 i_reset = 1'b0;
      #1;
      chk("rst_valid", 32'(o_valid), 32'd0);
      chk("rst_ready", 32'(o_ready), 32'd1);
      chk("rst_fields", {o_aluOp, o_opaSel, o_opbSel, o_rs1, o_rs2, o_rd, o_wbEn, o_illegal}, 32'd0);
      chk("rst_imm", o_imm, 32'd0);
      chk("rst_pc", o_pc, 32'd0);
      @(negedge i_clk);
      i_reset = 1'b1;
      mv = 1'b0;
      mon_en = 1'b1;
      step(1, 32'hFFF00093, 32'h0000_2000, 1, 0);
      step(0, 32'h0, 32'h0, 1, 0);
      step(0, 32'h0, 32'h0, 1, 0);
      chk("post_reset_drained", 32'(q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
